// File: rtl/mod_addsub_serial.sv
// mod_addsub_serial
//   Limb-serial modular adder/subtractor. Pass 1 (PH1) forms s = a +/- b one
//   LIMB slice per cycle and keeps the carry/borrow out of the top as flag f.
//   Pass 2 (PH2) forms t = s -/+ p the same way. The result is then either s
//   or t. Done is presented 2*NL+1 cycles after start is accepted.
//
//   Build option: define MOD_ADDSUB_SUB_EN to enable modular subtraction
//   (op=1). Without it, op is ignored and every request is a modular add.
//
// Parameters
//   WIDTH  operand/modulus/result width; must be a multiple of LIMB
//   LIMB   bits handled per cycle
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   request, only looked at while idle
//   op      0 = (a+b) mod p, 1 = (a-b) mod p (subtraction build only)
//   a, b    operands, each below p
//   p       modulus, at least 2
//   busy    high whenever not idle
//   done    one-cycle pulse while the result is first valid
//   result  modular result, held until overwritten by the next operation
module mod_addsub_serial #(
  parameter int WIDTH = 256,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int NL = WIDTH / LIMB;
  localparam int CW = (NL > 1) ? $clog2(NL) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CW-1:0]    cnt_r;
  logic             c_r;
  logic             f_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] s_r;
  logic [WIDTH-1:0] t_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;

  logic             last_s;
  logic             ph1_sub_s;
  logic             ph2_sub_s;
  logic [LIMB:0]    ph1_res_s;
  logic [LIMB:0]    ph2_res_s;
  logic [WIDTH-1:0] s_rot_s;
  logic [WIDTH-1:0] t_next_s;
  logic             use_t_s;
  logic [WIDTH-1:0] sel_s;

  // One limb of add (sub=0) or subtract (sub=1); top bit is carry or borrow.
  function automatic logic [LIMB:0] limb_op(input logic [LIMB-1:0] x,
                                            input logic [LIMB-1:0] y,
                                            input logic            cin,
                                            input logic            sub);
    logic [LIMB:0] r;
    if (sub) begin
      r = {1'b0, x} - {1'b0, y} - {{LIMB{1'b0}}, cin};
    end else begin
      r = {1'b0, x} + {1'b0, y} + {{LIMB{1'b0}}, cin};
    end
    return r;
  endfunction

  // Shift a word down by one limb and place a new limb at the top.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] x,
                                                input logic [LIMB-1:0]  top);
    return (x >> LIMB) | (WIDTH'(top) << (WIDTH - LIMB));
  endfunction

`ifdef MOD_ADDSUB_SUB_EN
  logic op_r;
`else
  logic unused_op_s;
  assign unused_op_s = op;
`endif

  // Datapath slice arithmetic and final result selection.
  always_comb begin
    last_s = (cnt_r == CW'(NL - 1));
`ifdef MOD_ADDSUB_SUB_EN
    ph1_sub_s = op_r;
    ph2_sub_s = ~op_r;
`else
    ph1_sub_s = 1'b0;
    ph2_sub_s = 1'b1;
`endif
    ph1_res_s = limb_op(a_r[LIMB-1:0], b_r[LIMB-1:0], c_r, ph1_sub_s);
    ph2_res_s = limb_op(s_r[LIMB-1:0], p_r[LIMB-1:0], c_r, ph2_sub_s);
    // s is rotated through PH2 so it is whole again after the last slice.
    s_rot_s  = shift_in(s_r, s_r[LIMB-1:0]);
    t_next_s = shift_in(t_r, ph2_res_s[LIMB-1:0]);
`ifdef MOD_ADDSUB_SUB_EN
    // Add: take t when {f,s} >= p. Sub: take t (s+p) when a-b borrowed.
    use_t_s = op_r ? f_r : (f_r | ~ph2_res_s[LIMB]);
`else
    use_t_s = f_r | ~ph2_res_s[LIMB];
`endif
    sel_s = use_t_s ? t_next_s : s_rot_s;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = start  ? PH1 : IDLE;
      PH1:     state_next_s = last_s ? PH2 : PH1;
      PH2:     state_next_s = last_s ? FIN : PH2;
      FIN:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture, limb-serial datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {CW{1'b0}};
      c_r      <= 1'b0;
      f_r      <= 1'b0;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      p_r      <= {WIDTH{1'b0}};
      s_r      <= {WIDTH{1'b0}};
      t_r      <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {WIDTH{1'b0}};
`ifdef MOD_ADDSUB_SUB_EN
      op_r     <= 1'b0;
`endif
    end else begin
      busy_r <= (state_next_s != IDLE);
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            p_r   <= p;
            cnt_r <= {CW{1'b0}};
            c_r   <= 1'b0;
            f_r   <= 1'b0;
`ifdef MOD_ADDSUB_SUB_EN
            op_r  <= op;
`endif
          end
        end
        PH1: begin
          a_r <= shift_in(a_r, {LIMB{1'b0}});
          b_r <= shift_in(b_r, {LIMB{1'b0}});
          s_r <= shift_in(s_r, ph1_res_s[LIMB-1:0]);
          if (last_s) begin
            f_r   <= ph1_res_s[LIMB];
            c_r   <= 1'b0;
            cnt_r <= {CW{1'b0}};
          end else begin
            c_r   <= ph1_res_s[LIMB];
            cnt_r <= cnt_r + CW'(1);
          end
        end
        PH2: begin
          s_r <= s_rot_s;
          p_r <= shift_in(p_r, p_r[LIMB-1:0]);
          t_r <= t_next_s;
          c_r <= ph2_res_s[LIMB];
          if (last_s) begin
            cnt_r    <= {CW{1'b0}};
            result_r <= sel_s;
            done_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        FIN: begin
          c_r <= 1'b0;
        end
        default: begin
          c_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_mod_addsub_serial.sv
// Self-checking bench for mod_addsub_serial (WIDTH=256, LIMB=64).
// Table of directed vectors run back to back, then hand-written sequences
// for start-while-busy and reset mid-operation.
module tb_mod_addsub_serial;

  logic         clk;
  logic         rst;
  logic         start;
  logic         op;
  logic [255:0] a;
  logic [255:0] b;
  logic [255:0] p;
  logic         busy;
  logic         done;
  logic [255:0] result;

  int checks;
  int failures;

  mod_addsub_serial #(.WIDTH(256), .LIMB(64)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .p      (p),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         op;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] p;
    logic [255:0] exp;
  } vec_t;

  task automatic check_val(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge of cycle 10 so the next call
  // issues its start in the idle cycle right after the done cycle.
  task automatic run_op(input logic o, input logic [255:0] aa, input logic [255:0] bb,
                        input logic [255:0] pp, output logic [255:0] res,
                        output int done_cyc, output int tim_err);
    op = o; a = aa; b = bb; p = pp; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = ~o;
    a  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    b  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    p  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    done_cyc = -1;
    tim_err  = 0;
    res      = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (busy !== (k <= 9)) tim_err++;
      if (done === 1'b1) begin
        if (done_cyc < 0) begin
          done_cyc = k;
          res = result;
        end else begin
          tim_err++;
        end
      end else if (done !== 1'b0) begin
        tim_err++;
      end
      if (k == 10 && result !== res) tim_err++;
    end
  endtask

  vec_t         vecs[14];
  logic [255:0] p1;
  logic [255:0] p2;
  logic [255:0] res;
  int           dcyc;
  int           terr;
  int           npulse;
  int           spurious;

  initial begin
    checks   = 0;
    failures = 0;
    p1 = (256'd1 << 255) - 256'd19;
    p2 = 256'd0 - 256'd189;

    vecs[0]  = '{"add_small",     1'b0, 256'd5,            256'd7,          p1,       256'd12};
    vecs[1]  = '{"add_wrap",      1'b0, p1 - 256'd1,       256'd2,          p1,       256'd1};
    vecs[2]  = '{"add_carry_top", 1'b0, p2 - 256'd1,       p2 - 256'd1,     p2,       p2 - 256'd2};
`ifdef MOD_ADDSUB_SUB_EN
    vecs[3]  = '{"sub_borrow",    1'b1, 256'd3,            256'd5,          p1,       p1 - 256'd2};
    vecs[4]  = '{"sub_plain",     1'b1, 256'd5,            256'd3,          p1,       256'd2};
    vecs[10] = '{"sub_neg_max",   1'b1, 256'd0,            p2 - 256'd1,     p2,       256'd1};
    vecs[11] = '{"sub_equal",     1'b1, 256'd7,            256'd7,          p1,       256'd0};
`else
    vecs[3]  = '{"op1_is_add_a",  1'b1, 256'd3,            256'd5,          p1,       256'd8};
    vecs[4]  = '{"op1_is_add_b",  1'b1, 256'd5,            256'd3,          p1,       256'd8};
    vecs[10] = '{"op1_is_add_c",  1'b1, 256'd0,            p2 - 256'd1,     p2,       p2 - 256'd1};
    vecs[11] = '{"op1_is_add_d",  1'b1, 256'd7,            256'd7,          p1,       256'd14};
`endif
    vecs[5]  = '{"add_zero",      1'b0, 256'd0,            256'd0,          p1,       256'd0};
    vecs[6]  = '{"add_eq_p",      1'b0, p1 - 256'd1,       256'd1,          p1,       256'd0};
    vecs[7]  = '{"add_p_minus1",  1'b0, p1 - 256'd1,       256'd0,          p1,       p1 - 256'd1};
    vecs[8]  = '{"add_eq_p2",     1'b0, p2 - 256'd1,       256'd1,          p2,       256'd0};
    vecs[9]  = '{"add_2pow256",   1'b0, 256'd1 << 255,     256'd1 << 255,   p2,       256'd189};
    vecs[12] = '{"add_mod2",      1'b0, 256'd1,            256'd1,          256'd2,   256'd0};
    vecs[13] = '{"add_limb_ripl", 1'b0, (256'd1 << 64) - 256'd1, 256'd1,    p1,       256'd1 << 64};

    // Reset state
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; p = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    check_val("reset_result", result, 256'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, issued back to back
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].p, res, dcyc, terr);
      check_val({vecs[i].name, "_result"}, res, vecs[i].exp);
      check_int({vecs[i].name, "_done_cycle"}, dcyc, 9);
      check_int({vecs[i].name, "_busy_done_hold"}, terr, 0);
    end

    // Start while busy: second start at cycle 3 must be ignored
    npulse = 0; dcyc = -1; res = '0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c >= 1 && done === 1'b1) begin
        npulse++;
        dcyc = c;
        res = result;
      end
      start = (c == 0 || c == 3);
      op = 1'b0;
      a = (c == 0) ? 256'd5 : 256'd1;
      b = (c == 0) ? 256'd7 : 256'd1;
      p = p1;
    end
    check_int("busy_ignore_pulses", npulse, 1);
    check_int("busy_ignore_done_cycle", dcyc, 9);
    check_val("busy_ignore_result", res, 256'd12);

    // Reset at cycle 5 (with a simultaneous start), new start at cycle 6
    spurious = 0; dcyc = -1; res = '0;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      if (c == 6) begin
        check_int("midreset_busy", int'(busy), 0);
        check_int("midreset_done", int'(done), 0);
        check_val("midreset_result", result, 256'd0);
      end
      if (c >= 1 && done === 1'b1) begin
        if (c == 15) begin
          dcyc = c;
          res = result;
        end else begin
          spurious++;
        end
      end
      rst = (c == 5);
      start = (c == 0 || c == 5 || c == 6);
      op = 1'b0;
      a = (c < 6) ? 256'd5 : p1 - 256'd1;
      b = (c < 6) ? 256'd7 : 256'd2;
      p = p1;
    end
    check_int("midreset_spurious_done", spurious, 0);
    check_int("after_reset_done_cycle", dcyc, 15);
    check_val("after_reset_result", res, 256'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_addsub_serial.md
MOD_ADDSUB_SERIAL -- requirements
Module: mod_addsub_serial

Interface
REQ-001 Parameter WIDTH, default 256: operand, modulus and result width in bits.
REQ-002 Parameter LIMB, default 64: bits processed per cycle; WIDTH SHALL be an integer multiple of LIMB; NL = WIDTH/LIMB.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  1  0 = (a+b) mod p, 1 = (a-b) mod p.
REQ-007 a  input  WIDTH  first operand; SHALL satisfy a < p; result unspecified otherwise.
REQ-008 b  input  WIDTH  second operand; SHALL satisfy b < p.
REQ-009 p  input  WIDTH  modulus; SHALL satisfy p >= 2.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse marking a valid result.
REQ-012 result  output  WIDTH  modular result; held stable from done until the next accepted start.

Function
REQ-013 FSM states: IDLE, PH1, PH2, FIN; encoding is implementer's choice.
REQ-014 IDLE with start=1: capture a, b, p, op into internal registers; go to PH1; limb counter = 0; carry/borrow = 0.
REQ-015 IDLE with start=0: remain in IDLE; result unchanged.
REQ-016 PH1: per cycle, one LIMB slice, LSB first: s_limb = a_limb + b_limb + carry (op=0) or a_limb - b_limb - borrow (op=1); store slice; propagate carry/borrow; exactly NL cycles.
REQ-017 PH1 exit: retain final carry (op=0) or borrow (op=1) as flag f; reset limb carry to 0; go to PH2.
REQ-018 PH2: per cycle, one slice: t = s - p (op=0) or t = s + p (op=1); LSB first; exactly NL cycles.
REQ-019 Selection, op=0: result = t if f=1 or the final PH2 borrow = 0 (i.e. {f,s} >= p), else s.
REQ-020 Selection, op=1: result = t (carry out of WIDTH discarded) if f=1, else s.
REQ-021 FIN: register result; done=1 for exactly this cycle; return to IDLE next cycle.
REQ-022 Latency: done SHALL be high exactly 2*NL+1 cycles after the edge that accepted start (9 cycles for defaults).
REQ-023 start asserted while busy=1 SHALL be ignored; captured operands SHALL not change.
REQ-024 Input ports may change freely after acceptance without affecting the operation in flight.
REQ-025 A start sampled in the IDLE cycle immediately after FIN SHALL be accepted (back-to-back throughput 2*NL+2 cycles).
REQ-026 All arithmetic SHALL be WIDTH+1 bits wide effectively; no intermediate overflow is permitted, including for a+b >= 2^WIDTH.

Reset
REQ-027 rst=1 at any edge, including mid-PH1/PH2/FIN: state = IDLE, busy=0, done=0, result=0, limb counter, carry and f = 0.
REQ-028 rst SHALL take priority over start in the same cycle; the first start is honoured in the cycle after rst deasserts.

Configuration
REQ-029 Macro MOD_ADDSUB_SUB_EN: when defined, op selects the subtraction per REQ-016/018/020.
REQ-030 Without MOD_ADDSUB_SUB_EN, op SHALL be ignored, every operation SHALL be modular addition, and subtract datapath logic SHALL not be synthesised; latency unchanged.

Verification (WIDTH=256, LIMB=64, P1 = 2^255-19, P2 = 2^256-189)
REQ-031 Add, no wrap: p=P1, a=5, b=7, op=0 -> done 9 cycles after start, result=12, busy high cycles 1-9.
REQ-032 Add, wrap: p=P1, a=P1-1, b=2, op=0 -> result=1.
REQ-033 Add, carry past WIDTH: p=P2, a=b=P2-1, op=0 -> result=P2-2.
REQ-034 Sub, borrow (MOD_ADDSUB_SUB_EN defined): p=P1, a=3, b=5, op=1 -> result=P1-2; a=5, b=3 -> result=2; undefined macro with a=3, b=5, op=1 -> result=8.
REQ-035 Busy/reset: start at cycle 0, second start with a=1, b=1 at cycle 3 -> ignored, first result delivered at cycle 9; rst at cycle 5 of a new operation -> done never pulses, result=0, busy=0 next cycle, new start accepted afterwards.
